// File: rtl/collision_pkg.sv
// Shared constants, state encoding and small arithmetic helpers for the
// collision scanner and its distance pipeline.
package collision_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Playfield and scan geometry.
  localparam int N_OBJ       = 10;
  localparam int IDX_W       = 4;
  localparam int COORD_W     = 8;
  localparam int DSQ_W       = 17;
  localparam int RADIUS      = 4;
  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int EDGE_MARGIN = 0;

  // Derived thresholds, sized to the datapath they are compared against.
  localparam logic [DSQ_W-1:0]   RADIUS_SQ = DSQ_W'(RADIUS * RADIUS);
  localparam logic [COORD_W-1:0] X_LO      = COORD_W'(EDGE_MARGIN);
  localparam logic [COORD_W-1:0] X_HI      = COORD_W'(SCREEN_W - 1 - EDGE_MARGIN);
  localparam logic [COORD_W-1:0] Y_LO      = COORD_W'(EDGE_MARGIN);
  localparam logic [COORD_W-1:0] Y_HI      = COORD_W'(SCREEN_H - 1 - EDGE_MARGIN);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_OBJ - 1);

  // Unsigned absolute difference; the larger operand is always the minuend
  // so the result never wraps.
  function automatic logic [COORD_W-1:0] abs_diff(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    logic [COORD_W-1:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

  // True when a coordinate pair lies on or inside the border margin.
  function automatic logic at_edge(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y
  );
    return (x <= X_LO) || (x >= X_HI) || (y <= Y_LO) || (y >= Y_HI);
  endfunction

  // Square of an 8-bit magnitude, widened to the distance width first so
  // the product cannot overflow.
  function automatic logic [DSQ_W-1:0] square(input logic [COORD_W-1:0] v);
    logic [DSQ_W-1:0] w;
    w = {{(DSQ_W-COORD_W){1'b0}}, v};
    return w * w;
  endfunction

endpackage

// File: rtl/collision_scanner_dist_pipe.sv
// Two-stage distance pipeline. Stage 1 registers |dx|, |dy| and the edge
// flag for one object; stage 2 forms dx^2+dy^2 and the radius compare
// combinationally so the owner can commit the result on the next edge.
module dist_pipe
  import collision_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic               in_active,
  input  logic [COORD_W-1:0] sx,
  input  logic [COORD_W-1:0] sy,
  input  logic [COORD_W-1:0] ox,
  input  logic [COORD_W-1:0] oy,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_crash,
  output logic               out_edge
);

  logic               s1_valid_r;
  logic [IDX_W-1:0]   s1_idx_r;
  logic               s1_active_r;
  logic [COORD_W-1:0] s1_dx_r;
  logic [COORD_W-1:0] s1_dy_r;
  logic               s1_edge_r;
  logic [DSQ_W-1:0]   dsq_s;

  // Stage 1: absolute differences, masked edge flag and sideband capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r  <= 1'b0;
      s1_idx_r    <= '0;
      s1_active_r <= 1'b0;
      s1_dx_r     <= '0;
      s1_dy_r     <= '0;
      s1_edge_r   <= 1'b0;
    end else begin
      s1_valid_r  <= in_valid;
      s1_idx_r    <= in_idx;
      s1_active_r <= in_active;
      s1_dx_r     <= abs_diff(sx, ox);
      s1_dy_r     <= abs_diff(sy, oy);
      s1_edge_r   <= in_active & at_edge(ox, oy);
    end
  end

  // Stage 2: squared distance and inclusive radius compare.
  always_comb begin
    dsq_s     = square(s1_dx_r) + square(s1_dy_r);
    out_valid = s1_valid_r;
    out_idx   = s1_idx_r;
    out_edge  = s1_edge_r;
    if (s1_active_r && (dsq_s <= RADIUS_SQ)) begin
      out_crash = 1'b1;
    end else begin
      out_crash = 1'b0;
    end
  end

endmodule

// File: rtl/collision_scanner.sv
// Frame-tick collision scanner: snapshots the player and all objects on a
// start request, streams the objects through dist_pipe one per cycle into
// shadow flags, then publishes crash/touch_edge together with a done pulse.
module collision_scanner
  import collision_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  self_x,
  input  logic [7:0]  self_y,
  input  logic [79:0] obj_x_flat,
  input  logic [79:0] obj_y_flat,
  input  logic [9:0]  obj_active,
  output logic        busy,
  output logic        done,
  output logic [9:0]  crash,
  output logic [9:0]  touch_edge
);

  state_t               state_r;
  logic [IDX_W-1:0]     idx_r;
  logic [COORD_W-1:0]   snap_sx_r;
  logic [COORD_W-1:0]   snap_sy_r;
  logic [79:0]          snap_ox_r;
  logic [79:0]          snap_oy_r;
  logic [N_OBJ-1:0]     snap_act_r;
  logic [N_OBJ-1:0]     shadow_crash_r;
  logic [N_OBJ-1:0]     shadow_edge_r;
  logic                 busy_r;
  logic                 done_r;
  logic [N_OBJ-1:0]     crash_r;
  logic [N_OBJ-1:0]     edge_r;

  logic                 feed_valid_s;
  logic [COORD_W-1:0]   feed_ox_s;
  logic [COORD_W-1:0]   feed_oy_s;
  logic                 feed_act_s;
  logic                 res_valid_s;
  logic [IDX_W-1:0]     res_idx_s;
  logic                 res_crash_s;
  logic                 res_edge_s;

  // Select the snapshotted object addressed by idx for the pipeline input.
  always_comb begin
    feed_ox_s  = snap_ox_r[{idx_r, 3'b000} +: COORD_W];
    feed_oy_s  = snap_oy_r[{idx_r, 3'b000} +: COORD_W];
    feed_act_s = snap_act_r[idx_r];
    if (state_r == ST_SCAN) begin
      feed_valid_s = 1'b1;
    end else begin
      feed_valid_s = 1'b0;
    end
  end

  dist_pipe u_dist_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (feed_valid_s),
    .in_idx    (idx_r),
    .in_active (feed_act_s),
    .sx        (snap_sx_r),
    .sy        (snap_sy_r),
    .ox        (feed_ox_s),
    .oy        (feed_oy_s),
    .out_valid (res_valid_s),
    .out_idx   (res_idx_s),
    .out_crash (res_crash_s),
    .out_edge  (res_edge_s)
  );

  // Scan controller: snapshot, index sequencing and atomic publication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      snap_sx_r  <= '0;
      snap_sy_r  <= '0;
      snap_ox_r  <= '0;
      snap_oy_r  <= '0;
      snap_act_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      crash_r    <= '0;
      edge_r     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            snap_sx_r  <= self_x;
            snap_sy_r  <= self_y;
            snap_ox_r  <= obj_x_flat;
            snap_oy_r  <= obj_y_flat;
            snap_act_r <= obj_active;
            idx_r      <= '0;
            busy_r     <= 1'b1;
            state_r    <= ST_SCAN;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        ST_SCAN: begin
          // idx parks on the last object so the select never leaves range.
          if (idx_r == IDX_LAST) begin
            state_r <= ST_FLUSH;
          end else begin
            idx_r   <= idx_r + 4'd1;
          end
        end
        ST_FLUSH: begin
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          crash_r <= shadow_crash_r;
          edge_r  <= shadow_edge_r;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Shadow flags: cleared when a scan launches, filled as results emerge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_crash_r <= '0;
      shadow_edge_r  <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      shadow_crash_r <= '0;
      shadow_edge_r  <= '0;
    end else if (res_valid_s) begin
      shadow_crash_r[res_idx_s] <= res_crash_s;
      shadow_edge_r[res_idx_s]  <= res_edge_s;
    end else begin
      shadow_crash_r <= shadow_crash_r;
      shadow_edge_r  <= shadow_edge_r;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign crash      = crash_r;
  assign touch_edge = edge_r;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner: hand-computed flag vectors, latency,
// snapshot isolation, ignored start, back-to-back restart and mid-scan reset.
module tb_collision_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  self_x;
  logic [7:0]  self_y;
  logic [79:0] obj_x_flat;
  logic [79:0] obj_y_flat;
  logic [9:0]  obj_active;
  logic        busy;
  logic        done;
  logic [9:0]  crash;
  logic [9:0]  touch_edge;

  int errors = 0;
  int checks = 0;
  int lat;
  int ndone;
  int first_k;
  int second_k;

  collision_scanner dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .self_x     (self_x),
    .self_y     (self_y),
    .obj_x_flat (obj_x_flat),
    .obj_y_flat (obj_y_flat),
    .obj_active (obj_active),
    .busy       (busy),
    .done       (done),
    .crash      (crash),
    .touch_edge (touch_edge)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_obj(input int i, input logic [7:0] x, input logic [7:0] y);
    obj_x_flat[i*8 +: 8] = x;
    obj_y_flat[i*8 +: 8] = y;
  endtask

  task automatic fill_far();
    for (int i = 0; i < 10; i++) set_obj(i, 8'd20, 8'd20);
    obj_active = 10'h3FF;
  endtask

  task automatic scen2();
    fill_far();
    self_x = 8'd80;
    self_y = 8'd60;
    set_obj(3, 8'd83, 8'd60);
  endtask

  // Pulse start for one edge, then watch 20 cycles for done pulses.
  task automatic run_scan(output int l, output int n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        n++;
        if (l == 0) l = k;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    self_x = 8'd0;
    self_y = 8'd0;
    obj_x_flat = '0;
    obj_y_flat = '0;
    obj_active = '0;
    fill_far();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset then idle
    chk("rst_crash", 32'(crash), 32'd0);
    chk("rst_edge", 32'(touch_edge), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("idle_no_done", 32'(ndone), 32'd0);

    // 2: basic hit, with busy right after the start edge
    scen2();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("s2_busy", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
    end
    chk("s2_latency", 32'(lat), 32'd12);
    chk("s2_crash", 32'(crash), 32'h008);
    chk("s2_edge", 32'(touch_edge), 32'd0);
    chk("s2_busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("s2_done_pulse", 32'(done), 32'd0);
    chk("s2_hold", 32'(crash), 32'h008);

    // 3: radius boundary (dsq 16 hit, 17 miss, 0 hit)
    fill_far();
    self_x = 8'd50;
    self_y = 8'd50;
    set_obj(0, 8'd54, 8'd50);
    set_obj(1, 8'd54, 8'd51);
    set_obj(2, 8'd50, 8'd50);
    run_scan(lat, ndone);
    chk("s3_latency", 32'(lat), 32'd12);
    chk("s3_crash", 32'(crash), 32'h005);
    chk("s3_edge", 32'(touch_edge), 32'd0);

    // 4: edge detection and inactive masking
    fill_far();
    self_x = 8'd3;
    self_y = 8'd60;
    set_obj(5, 8'd0, 8'd40);
    set_obj(6, 8'd159, 8'd40);
    set_obj(7, 8'd10, 8'd119);
    set_obj(8, 8'd3, 8'd60);
    obj_active = 10'b10_0111_1111;
    run_scan(lat, ndone);
    chk("s4_edge", 32'(touch_edge), 32'h060);
    chk("s4_crash", 32'(crash), 32'd0);

    // 5: snapshot isolation and start ignored while busy
    scen2();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin
        set_obj(4, 8'd80, 8'd60);
        start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
    end
    chk("s5_one_done", 32'(ndone), 32'd1);
    chk("s5_latency", 32'(lat), 32'd12);
    chk("s5_snapshot", 32'(crash), 32'h008);
    run_scan(lat, ndone);
    chk("s5_rescan", 32'(crash), 32'h018);

    // start held high restarts on the first IDLE cycle: period 13
    scen2();
    start = 1'b1;
    @(posedge clk); #1;
    first_k = 0;
    second_k = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 13) start = 1'b0;
      if (done) begin
        if (first_k == 0) first_k = k;
        else if (second_k == 0) second_k = k;
      end
    end
    chk("held_first", 32'(first_k), 32'd12);
    chk("held_second", 32'(second_k), 32'd25);

    // 6: reset mid-scan
    run_scan(lat, ndone);
    chk("s6_pre_crash", 32'(crash), 32'h008);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("s6_crash_clr", 32'(crash), 32'd0);
    chk("s6_busy_clr", 32'(busy), 32'd0);
    chk("s6_done_clr", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("s6_no_done", 32'(ndone), 32'd0);
    chk("s6_edge_clr", 32'(touch_edge), 32'd0);
    run_scan(lat, ndone);
    chk("s6_fresh_lat", 32'(lat), 32'd12);
    chk("s6_fresh_crash", 32'(crash), 32'h008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Sequential producer of the per-object collision and edge flags consumed by the game-over logic.
- On a start pulse, snapshots the player position and all 10 object positions, then scans the objects one per cycle through a 2-stage squared-distance pipeline.
- Publishes crash[9:0] and touch_edge[9:0] atomically, with a one-cycle done pulse.
- Sits between the object movement logic and the game-over handler; runs once per frame tick.

Parameters:
- N_OBJ, 10, number of objects scanned (index width 4 bits).
- RADIUS, 4, collision radius in pixels; collision when dx²+dy² <= RADIUS*RADIUS.
- SCREEN_W, 160, playfield width in pixels.
- SCREEN_H, 120, playfield height in pixels.
- EDGE_MARGIN, 0, pixels from the border that count as touching the edge.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  scan request; sampled only in IDLE.
- self_x  in  8  player x.
- self_y  in  8  player y.
- obj_x_flat  in  80  object x coordinates; object i at bits [8i+7:8i].
- obj_y_flat  in  80  object y coordinates, same packing.
- obj_active  in  10  per-object enable; inactive objects never flag.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when crash/touch_edge are updated.
- crash  out  10  per-object collision flags, held until the next done.
- touch_edge  out  10  per-object edge flags, held until the next done.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, crash=0, touch_edge=0; snapshot, pipeline and shadow registers cleared.
- States: IDLE -> SCAN -> FLUSH -> DONE -> IDLE.
- IDLE:
  - On start=1, edge E0 loads snapshot registers (self_x/y, obj_x/y_flat, obj_active), sets idx=0, clears the shadow crash/edge registers and moves to SCAN.
  - start=0 keeps the state in IDLE.
- SCAN:
  - Each edge E1..E10 registers stage 1 for object idx.
  - Stage 1 computes dx=|sx-ox| and dy=|sy-oy| as 8-bit unsigned values, never wrapping negative.
  - Stage 1 also computes the edge flag: ox<=EDGE_MARGIN, or ox>=SCREEN_W-1-EDGE_MARGIN, or the same test on oy against SCREEN_H. The flag is ANDed with active.
  - Stage 1 carries idx and active forward.
  - idx increments each edge. At idx=N_OBJ-1 (E10) the state moves to FLUSH.
- Stage 2:
  - One edge after stage 1, computes dsq=dx*dx+dy*dy at 17 bits (no overflow: max 2*255²=130050).
  - Writes shadow_crash[idx]=active & (dsq <= RADIUS*RADIUS) and shadow_edge[idx].
  - Object 9 is written at E11, in the FLUSH state; FLUSH then moves to DONE.
- DONE:
  - At edge E12, crash<=shadow_crash and touch_edge<=shadow_edge; done=1 for the cycle following E12; next state IDLE.
  - Latency start-sampled to done: 12 cycles.
  - Minimum start-to-start period: 13 cycles.
- Outputs change only on the done edge. They are never partially updated mid-scan.
- start while busy (SCAN/FLUSH/DONE) is ignored and not queued. start held high continuously restarts a scan on the first IDLE cycle after DONE.
- Input changes after E0 do not affect the in-flight scan, because the snapshot is taken at E0.
- Distance of exactly RADIUS (e.g. dx=4, dy=0) is a crash; dsq=17 with RADIUS=4 is not.
- A player exactly on top of an object (dsq=0) is a crash if that object is active.
- Reset asserted mid-scan:
  - Returns to IDLE immediately and clears the outputs to 0.
  - done is not asserted for the aborted scan.

Decomposition:
- Package collision_pkg holds:
  - State encoding: IDLE=2'd0, SCAN=2'd1, FLUSH=2'd2, DONE=2'd3.
  - N_OBJ, SCREEN_W, SCREEN_H defaults.
  - Index width constant IDX_W=4.
- One sub-module, dist_pipe: the 2-stage absolute-difference / square-sum / compare pipeline with idx and active sideband.
- The FSM, snapshot and shadow registers live in collision_scanner.

Test Plan:
1. Reset then idle: with start=0, after reset -> crash=0, touch_edge=0, busy=0, done never pulses.
2. Basic hit:
   - Stimulus: self=(80,60), obj3=(83,60), all others (20,20), all active, start pulse.
   - Required: done exactly 12 cycles later, crash=10'b0000001000, touch_edge=0.
3. Radius boundary:
   - Stimulus: self=(50,50), obj0=(54,50) (dsq=16), obj1=(54,51) (dsq=17), obj2=(50,50) (dsq=0).
   - Required: crash[2:0]=3'b101.
4. Edge and inactive masking:
   - Stimulus: obj5=(0,40) active, obj6=(159,40) active, obj7=(10,119) inactive, obj8=(3,60) active with self=(3,60) but obj8 inactive.
   - Required: touch_edge=10'b0001100000, crash[8]=0.
5. Snapshot and ignored start:
   - Stimulus: start scan; at cycle 3 move obj4 onto the player and pulse start again.
   - Required: result shows no crash[4], only one done. A second scan started after IDLE shows crash[4]=1.
6. Reset mid-scan:
   - Stimulus: a scenario-2 scan completes; start a new scan and assert reset at cycle 6.
   - Required: crash=0 immediately, busy=0, no done.
   - A fresh scan afterwards reproduces the scenario-2 result.
